// File: rtl/rs_en_pkg.sv
// Shared types, step table and helpers for rs_en_exerciser.
// The content of step 5 depends on RS_EN_EXERCISER_ILLEGAL_EN.
package rs_en_pkg;

    localparam int NUM_STEPS = 7;

    typedef enum logic [1:0] {
        STEP_RESET   = 2'd0,
        STEP_HOLD    = 2'd1,
        STEP_SET     = 2'd2,
        STEP_ILLEGAL = 2'd3
    } step_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

`ifdef RS_EN_EXERCISER_ILLEGAL_EN
    localparam step_e STEP5 = STEP_ILLEGAL;
`else
    localparam step_e STEP5 = STEP_HOLD;
`endif

    localparam step_e STEP_TABLE [NUM_STEPS] = '{
        STEP_RESET, STEP_HOLD, STEP_SET, STEP_HOLD, STEP_RESET, STEP5, STEP_SET
    };

    // {S,R} levels driven onto the latch for a given step kind.
    function automatic logic [1:0] step_sr(input step_e st);
        case (st)
            STEP_RESET:   return 2'b01;
            STEP_SET:     return 2'b10;
            STEP_ILLEGAL: return 2'b11;
            default:      return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/rs_en_exerciser_sync2.sv
// Two-flop synchronizer for one asynchronous level, async active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rs_en_exerciser.sv
// Self-checking stimulus generator for the gated RS latch RS_EN.
// Define RS_EN_EXERCISER_ILLEGAL_EN to drive (1,1) on step 5 and leave it unchecked.
module rs_en_exerciser
    import rs_en_pkg::*;
#(
    parameter int HALF_PERIOD  = 50,
    parameter int SETUP_CYCLES = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       drv_c,
    output logic       drv_s,
    output logic       drv_r,
    input  logic       q_in,
    input  logic       qn_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [2:0] err_step
);

    localparam int PULSE_LEN = 4 * HALF_PERIOD;
    localparam int CNT_MAX   = (PULSE_LEN > SETUP_CYCLES) ? PULSE_LEN : SETUP_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] HP_1       = CNT_W'(HALF_PERIOD);
    localparam logic [CNT_W-1:0] HP_2       = CNT_W'(2 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] HP_3       = CNT_W'(3 * HALF_PERIOD);
    localparam logic [2:0]       LAST_STEP  = 3'(NUM_STEPS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       step_q, step_d;

    logic       drv_c_q, drv_c_d;
    logic       drv_s_q, drv_s_d;
    logic       drv_r_q, drv_r_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_count_q, err_count_d;
    logic [2:0] err_step_q, err_step_d;
    logic       model_q, model_d;
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
    logic       unknown_q, unknown_d;
    logic       unk_next;
`endif

    logic       q_sync;
    logic       qn_sync;
    logic       run_start;
    logic       step_end;
    logic       enter_setup;
    step_e      cur_step;
    logic       exp_val;
    logic       checked;
    logic       step_fail;
    logic [1:0] next_sr;

    sync2 u_sync_q (
        .clk (clk),
        .rst (rst),
        .d_i (q_in),
        .q_o (q_sync)
    );

    sync2 u_sync_qn (
        .clk (clk),
        .rst (rst),
        .d_i (qn_in),
        .q_o (qn_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    step_d  = '0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d = '0;
                    if (step_q == LAST_STEP) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SETUP;
                        step_d  = step_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign run_start   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start;
    assign step_end    = (state_q == ST_PULSE) && (cnt_q == PULSE_LAST);
    assign enter_setup = (state_d == ST_SETUP) && (state_q != ST_SETUP);
    assign next_sr     = step_sr(STEP_TABLE[step_d]);

    // Reference model: expected Q after the current step, and whether it is checked.
    always_comb begin
        cur_step = STEP_TABLE[step_q];
        case (cur_step)
            STEP_RESET: exp_val = 1'b0;
            STEP_SET:   exp_val = 1'b1;
            default:    exp_val = model_q;
        endcase
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
        unk_next = unknown_q;
        if ((cur_step == STEP_RESET) || (cur_step == STEP_SET)) begin
            unk_next = 1'b0;
        end else if (cur_step == STEP_ILLEGAL) begin
            unk_next = 1'b1;
        end
        checked = !unk_next;
`else
        checked = 1'b1;
`endif
        step_fail = checked && ((q_sync != exp_val) || (qn_sync == q_sync));
    end

    always_comb begin
        // drv_c is high during the first and third half-periods of the pulse phase.
        drv_c_d = (state_d == ST_PULSE) &&
                  ((cnt_d < HP_1) || ((cnt_d >= HP_2) && (cnt_d < HP_3)));
        drv_s_d = drv_s_q;
        drv_r_d = drv_r_q;
        if (enter_setup) begin
            drv_s_d = next_sr[1];
            drv_r_d = next_sr[0];
        end
        busy_d      = (state_d == ST_SETUP) || (state_d == ST_PULSE);
        done_d      = done_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        err_step_d  = err_step_q;
        model_d     = model_q;
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
        unknown_d   = unknown_q;
`endif
        if (run_start) begin
            done_d      = 1'b0;
            pass_d      = 1'b0;
            err_count_d = '0;
            err_step_d  = '0;
            model_d     = 1'b0;
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
            unknown_d   = 1'b0;
`endif
        end
        if (step_end) begin
            model_d = exp_val;
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
            unknown_d = unk_next;
`endif
            if (step_fail) begin
                err_count_d = err_count_q + 3'd1;
                if (err_count_q == 3'd0) begin
                    err_step_d = step_q;
                end
            end
            if (step_q == LAST_STEP) begin
                done_d = 1'b1;
                pass_d = !step_fail && (err_count_q == 3'd0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drv_c_q     <= 1'b0;
            drv_s_q     <= 1'b0;
            drv_r_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            err_step_q  <= '0;
            model_q     <= 1'b0;
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
            unknown_q   <= 1'b0;
`endif
        end else begin
            drv_c_q     <= drv_c_d;
            drv_s_q     <= drv_s_d;
            drv_r_q     <= drv_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            err_step_q  <= err_step_d;
            model_q     <= model_d;
`ifdef RS_EN_EXERCISER_ILLEGAL_EN
            unknown_q   <= unknown_d;
`endif
        end
    end

    assign drv_c     = drv_c_q;
    assign drv_s     = drv_s_q;
    assign drv_r     = drv_r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_count_q;
    assign err_step  = err_step_q;

endmodule
